// File: rtl/iobus_pkg.sv
// Shared types and constants for the MMIO IOBUS arbiter: FSM states,
// the MMIO address window prefix and the wrapper's peripheral addresses.
package iobus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0]  MMIO_PREFIX = 8'h11;

  localparam logic [31:0] SWITCHES_AD = 32'h1100_0000;
  localparam logic [31:0] LEDS_AD     = 32'h1108_0000;
  localparam logic [31:0] SSEG_AD     = 32'h110C_0000;

  function automatic logic in_mmio_window(input logic [31:0] addr,
                                          input logic [7:0]  prefix);
    return addr[31:24] == prefix;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: prefers the requester that did not win last,
// falls back to the other so a lone requester is never blocked.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (last_i) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end else begin
      if (req_i[1])      gnt_o = 2'b10;
      else if (req_i[0]) gnt_o = 2'b01;
    end
  end

endmodule

// File: rtl/iobus_arbiter.sv
// Shares the single MMIO IOBUS between two masters (M0 = MCU, M1 = secondary)
// with round-robin fairness, fixed access latency and out-of-window rejection.
module iobus_arbiter #(
  parameter int unsigned ACCESS_LAT  = 1,
  parameter logic [7:0]  MMIO_PREFIX = iobus_pkg::MMIO_PREFIX
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        M0_REQ,
  input  logic [31:0] M0_ADDR,
  input  logic        M0_WR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_GNT,
  output logic        M0_DONE,
  output logic        M0_ERR,
  output logic [31:0] M0_RDATA,
  input  logic        M1_REQ,
  input  logic [31:0] M1_ADDR,
  input  logic        M1_WR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_GNT,
  output logic        M1_DONE,
  output logic        M1_ERR,
  output logic [31:0] M1_RDATA,
  output logic [31:0] BUS_ADDR,
  output logic        BUS_WR,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA
);

  import iobus_pkg::*;

  localparam int unsigned     CNT_W    = $clog2(ACCESS_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_LAT - 1);

  state_t            state_q, state_d;
  logic              last_q,  last_d;
  logic              win_q,   win_d;
  logic              gnt_q,   gnt_d;
  logic              err_q,   err_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [31:0]       addr_q,  addr_d;
  logic              wr_q,    wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0]        arb_gnt;
  logic              sel_m1;
  logic [31:0]       sel_addr;
  logic              sel_wr;
  logic [31:0]       sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req_i  ({M1_REQ, M0_REQ}),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  assign sel_m1    = arb_gnt[1];
  assign sel_addr  = sel_m1 ? M1_ADDR  : M0_ADDR;
  assign sel_wr    = sel_m1 ? M1_WR    : M0_WR;
  assign sel_wdata = sel_m1 ? M1_WDATA : M0_WDATA;

  // Control state: reset aborts any transaction in flight without a DONE.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transaction latches: only observed through state-gated outputs.
  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt_d   = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          win_d   = sel_m1;
          gnt_d   = 1'b1;
          addr_d  = sel_addr;
          wr_d    = sel_wr;
          wdata_d = sel_wdata;
          if (in_mmio_window(sel_addr, MMIO_PREFIX)) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            err_d   = 1'b0;
          end else begin
            // Rejected addresses skip the bus and answer immediately.
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      BUSY: begin
        if (cnt_q == '0) begin
          rdata_d = wr_q ? 32'h0 : BUS_RDATA;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  logic bus_act;
  logic resp;

  always_comb begin
    bus_act   = (state_q == BUSY);
    resp      = (state_q == RESP);

    BUS_ADDR  = bus_act ? addr_q  : 32'h0;
    BUS_WDATA = bus_act ? wdata_q : 32'h0;
    // gnt_q is high only in the first BUSY cycle, giving one strobe per write.
    BUS_WR    = bus_act & gnt_q & wr_q;

    M0_GNT    = gnt_q & ~win_q;
    M1_GNT    = gnt_q &  win_q;

    M0_DONE   = resp & ~win_q;
    M1_DONE   = resp &  win_q;
    M0_ERR    = M0_DONE & err_q;
    M1_ERR    = M1_DONE & err_q;
    M0_RDATA  = M0_DONE ? rdata_q : 32'h0;
    M1_RDATA  = M1_DONE ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_iobus_arbiter.sv
// Scoreboard bench for iobus_arbiter: drivers queue the expected grants,
// bus writes and responses; a negedge monitor pops and compares them.
module tb_iobus_arbiter;
  import iobus_pkg::*;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        M0_REQ, M0_WR, M1_REQ, M1_WR;
  logic [31:0] M0_ADDR, M0_WDATA, M1_ADDR, M1_WDATA;
  logic        M0_GNT, M0_DONE, M0_ERR, M1_GNT, M1_DONE, M1_ERR;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic [31:0] BUS_ADDR, BUS_WDATA, BUS_RDATA;
  logic        BUS_WR;
  logic [31:0] sw_val;

  iobus_arbiter #(.ACCESS_LAT(LAT), .MMIO_PREFIX(8'h11)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WR(M0_WR), .M0_WDATA(M0_WDATA),
    .M0_GNT(M0_GNT), .M0_DONE(M0_DONE), .M0_ERR(M0_ERR), .M0_RDATA(M0_RDATA),
    .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WR(M1_WR), .M1_WDATA(M1_WDATA),
    .M1_GNT(M1_GNT), .M1_DONE(M1_DONE), .M1_ERR(M1_ERR), .M1_RDATA(M1_RDATA),
    .BUS_ADDR(BUS_ADDR), .BUS_WR(BUS_WR), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA)
  );

  always #5 CLK = ~CLK;

  // Peripheral mux model: switches are readable, everything else reads 0.
  assign BUS_RDATA = (BUS_ADDR == SWITCHES_AD) ? sw_val : 32'h0;

  typedef struct packed { logic m; logic err; logic [31:0] rdata; } resp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } bw_t;

  resp_t resp_q[$];
  bw_t   bw_q[$];
  logic  gnt_exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_gnt_cyc = 0;
  logic rst_d = 1'b0;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_d <= RST_N;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  task automatic bus_quiet_chk();
    chk("rejected_bus_quiet", BUS_ADDR | BUS_WDATA | {31'b0, BUS_WR}, 32'h0);
  endtask

  // Monitor
  always @(negedge CLK) begin
    resp_t r;
    bw_t   b;
    logic  em;
    logic  any;
    if (cyc > 0 && !rst_d) begin
      any = M0_GNT | M0_DONE | M0_ERR | (|M0_RDATA) | M1_GNT | M1_DONE | M1_ERR |
            (|M1_RDATA) | (|BUS_ADDR) | BUS_WR | (|BUS_WDATA);
      chk("reset_outputs_zero", {31'b0, any}, 32'h0);
    end else if (cyc > 0) begin
      if (M0_GNT && M1_GNT) begin
        fail("gnt_onehot", "got both GNT high, required one");
      end else if (M0_GNT || M1_GNT) begin
        if (gnt_exp_q.size() == 0) begin
          fail("unexpected_gnt", $sformatf("got GNT for M%0d, required none", M1_GNT));
        end else begin
          em = gnt_exp_q.pop_front();
          chk("gnt_master", {31'b0, M1_GNT}, {31'b0, em});
        end
        last_gnt_cyc = cyc;
      end

      if (M0_DONE && M1_DONE) begin
        fail("done_onehot", "got both DONE high, required one");
      end else if (M0_DONE || M1_DONE) begin
        if (resp_q.size() == 0) begin
          fail("unexpected_done", $sformatf("got DONE for M%0d, required none", M1_DONE));
        end else begin
          r = resp_q.pop_front();
          chk("done_master", {31'b0, M1_DONE}, {31'b0, r.m});
          chk("done_err", {31'b0, M1_DONE ? M1_ERR : M0_ERR}, {31'b0, r.err});
          chk("done_rdata", M1_DONE ? M1_RDATA : M0_RDATA, r.rdata);
          chk("done_latency", cyc - last_gnt_cyc, r.err ? 0 : LAT);
        end
      end

      if (!M0_DONE) chk("m0_quiet", M0_RDATA | {31'b0, M0_ERR}, 32'h0);
      if (!M1_DONE) chk("m1_quiet", M1_RDATA | {31'b0, M1_ERR}, 32'h0);

      if (BUS_WR) begin
        if (bw_q.size() == 0) begin
          fail("unexpected_bus_wr", $sformatf("got strobe addr %h, required none", BUS_ADDR));
        end else begin
          b = bw_q.pop_front();
          chk("bus_wr_addr", BUS_ADDR, b.addr);
          chk("bus_wr_data", BUS_WDATA, b.data);
        end
      end
    end
  end

  task automatic set_m(input logic m, input logic req, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    if (!m) begin
      M0_REQ = req; M0_ADDR = a; M0_WR = w; M0_WDATA = d;
    end else begin
      M1_REQ = req; M1_ADDR = a; M1_WR = w; M1_WDATA = d;
    end
  endtask

  task automatic expect_txn(input logic m, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic e, input logic [31:0] rd);
    resp_t r;
    bw_t   b;
    gnt_exp_q.push_back(m);
    r.m = m; r.err = e; r.rdata = rd;
    resp_q.push_back(r);
    if (w && !e) begin
      b.addr = a; b.data = d;
      bw_q.push_back(b);
    end
  endtask

  task automatic wait_gnt(input logic m, input bit quiet);
    int k = 0;
    while (!(m ? M1_GNT : M0_GNT) && k < 40) begin
      @(negedge CLK);
      if (quiet) bus_quiet_chk();
      k++;
    end
    if (k == 40) fail("gnt_timeout", $sformatf("no GNT for M%0d within 40 cycles", m));
  endtask

  task automatic wait_drain(input bit quiet);
    int k = 0;
    while (resp_q.size() != 0 && k < 60) begin
      @(negedge CLK);
      if (quiet) bus_quiet_chk();
      k++;
    end
    if (resp_q.size() != 0)
      fail("done_timeout", $sformatf("%0d responses outstanding", resp_q.size()));
    @(negedge CLK);
  endtask

  // One transaction; inputs are scrambled after GNT to prove they were latched.
  task automatic run_one(input logic m, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic e, input logic [31:0] rd,
                         input bit late_drop, input bit quiet);
    expect_txn(m, a, w, d, e, rd);
    @(negedge CLK);
    set_m(m, 1'b1, a, w, d);
    wait_gnt(m, quiet);
    if (late_drop) @(negedge CLK);
    set_m(m, 1'b0, 32'hDEAD_BEEF, ~w, 32'hFFFF_FFFF);
    wait_drain(quiet);
  endtask

  // Both masters hold REQ for n grants; M0 is expected to win the first.
  task automatic run_pair(input int n);
    int g = 0;
    int k = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) expect_txn(1'b0, SWITCHES_AD, 1'b0, 32'h0, 1'b0, sw_val);
      else            expect_txn(1'b1, SSEG_AD, 1'b1, 32'h0000_00C3, 1'b0, 32'h0);
    end
    @(negedge CLK);
    set_m(1'b0, 1'b1, SWITCHES_AD, 1'b0, 32'h0);
    set_m(1'b1, 1'b1, SSEG_AD, 1'b1, 32'h0000_00C3);
    while (g < n && k < 200) begin
      @(negedge CLK);
      if (M0_GNT || M1_GNT) g++;
      k++;
    end
    if (g < n) fail("pair_timeout", $sformatf("got %0d grants, required %0d", g, n));
    set_m(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    wait_drain(1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    sw_val = 32'h0;
    set_m(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_m(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // M0 write to LEDs
    run_one(1'b0, LEDS_AD, 1'b1, 32'h0000_A5A5, 1'b0, 32'h0, 1'b0, 1'b0);

    // M1 read of switches
    sw_val = 32'h0000_1234;
    run_one(1'b1, SWITCHES_AD, 1'b0, 32'h0, 1'b0, 32'h0000_1234, 1'b0, 1'b0);

    // Sustained contention: strict alternation M0,M1,...
    sw_val = 32'h0000_0F0F;
    run_pair(6);

    // Out-of-window read is rejected without touching the bus
    run_one(1'b1, 32'h2000_0000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);

    // Unmapped address inside the window reads 0 with no error
    run_one(1'b0, 32'h1104_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset in the second BUSY cycle of an M0 write: strobe happens, no DONE
    begin
      bw_t b;
      gnt_exp_q.push_back(1'b0);
      b.addr = LEDS_AD; b.data = 32'h0000_005A;
      bw_q.push_back(b);
      @(negedge CLK);
      set_m(1'b0, 1'b1, LEDS_AD, 1'b1, 32'h0000_005A);
      wait_gnt(1'b0, 1'b0);
      @(negedge CLK);
      RST_N = 1'b0;
      set_m(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);
    end
    run_one(1'b1, SWITCHES_AD, 1'b0, 32'h0, 1'b0, sw_val, 1'b0, 1'b0);

    // Reset restores LAST=1 even when M0 was the last winner
    run_one(1'b0, SSEG_AD, 1'b1, 32'h0000_0011, 1'b0, 32'h0, 1'b0, 1'b0);
    pulse_reset();
    run_pair(2);

    // M0 drops REQ one cycle after GNT: still exactly one DONE, no new grant
    run_one(1'b0, SSEG_AD, 1'b1, 32'h0000_0077, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (10) @(negedge CLK);

    chk("queues_empty", resp_q.size() + gnt_exp_q.size() + bw_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
